// File: rtl/lsu.sv
// Load/store unit: accepts one MEM-stage access, checks alignment, runs a req/ack
// word-addressed memory transaction and returns the extended load data.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_align,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_exc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW = 32;

    localparam logic [1:0] ALIGN_WORD = 2'b00;
    localparam logic [1:0] ALIGN_HALF = 2'b01;
    localparam logic [1:0] ALIGN_BYTE = 2'b10;

    localparam logic [1:0] EXC_ADEL = 2'b01;
    localparam logic [1:0] EXC_ADES = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [1:0]      align_q, off_q;
    logic            sign_q;
    logic            misaligned_c;
    logic [3:0]      be_c;
    logic [DW-1:0]   wdata_c, load_c;
    logic [15:0]     half_c;
    logic [7:0]      byte_c;
    logic            accept_c;

    assign accept_c = (state == IDLE) && req_valid;

    // Alignment check, byte lanes and lane-replicated store data for the incoming request
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = '0;
        case (req_align)
            ALIGN_WORD: begin
                misaligned_c = |req_addr[1:0];
                be_c         = 4'b1111;
                wdata_c      = req_wdata;
            end
            ALIGN_HALF: begin
                misaligned_c = req_addr[0];
                be_c         = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{req_wdata[15:0]}};
            end
            ALIGN_BYTE: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    // Lane selection and extension of the returned read word
    always_comb begin
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (off_q)
            2'd0:    byte_c = mem_rdata[7:0];
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        case (align_q)
            ALIGN_WORD: load_c = mem_rdata;
            ALIGN_HALF: load_c = {{16{sign_q & half_c[15]}}, half_c};
            ALIGN_BYTE: load_c = {{24{sign_q & byte_c[7]}}, byte_c};
            default:    load_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_valid) state_d = misaligned_c ? RESP : ACCESS;
            ACCESS:  if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, loaded from the next state and the accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_exc   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            align_q   <= '0;
            off_q     <= '0;
            sign_q    <= 1'b0;
        end else begin
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            rsp_valid <= (state_d == RESP);
            mem_req   <= (state_d == ACCESS);
            rsp_rdata <= '0;
            rsp_exc   <= '0;
            if (accept_c) begin
                align_q <= req_align;
                off_q   <= req_addr[1:0];
                sign_q  <= req_sign;
                if (misaligned_c) begin
                    rsp_exc <= req_we ? EXC_ADES : EXC_ADEL;
                end else begin
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_be    <= be_c;
                    mem_wdata <= wdata_c;
                end
            end
            if ((state == ACCESS) && mem_ack && !mem_we) rsp_rdata <= load_c;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: reset, stores, loads, misalignment, back-to-back, reset abort.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_align = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_align(req_align), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and services memory; lat = cycles from T0 until rsp_valid is seen
    task automatic run_req(input logic we, input logic [1:0] al, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, output int lat, output int reqc,
                           output logic [3:0] be, output logic [31:0] maddr,
                           output logic [31:0] mwdata, output logic mwe,
                           output logic [31:0] rdata, output logic [1:0] exc,
                           output logic stable);
        int w;
        req_valid = 1'b1; req_we = we; req_align = al; req_sign = sg;
        req_addr = ad; req_wdata = wd;
        step();
        req_valid = 1'b0; req_wdata = 32'h5555_5555; req_addr = 32'hFFFF_FFFF;
        lat = 0; reqc = 0; w = 0; stable = 1'b1;
        be = mem_be; maddr = mem_addr; mwdata = mem_wdata; mwe = mem_we;
        while (!rsp_valid && lat < 50) begin
            if (mem_req) begin
                reqc++;
                if (mem_be !== be || mem_addr !== maddr || mem_wdata !== mwdata || mem_we !== mwe)
                    stable = 1'b0;
                if (w >= waits) begin mem_ack = 1'b1; mem_rdata = rd; end
                w++;
            end
            step();
            mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
            lat++;
        end
        rdata = rsp_rdata; exc = rsp_exc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_word_store();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (ma !== 32'h10) begin fails++; $display("FAIL wst_addr got %h exp 00000010", ma); end
        tests++; if (be !== 4'b1111) begin fails++; $display("FAIL wst_be got %b exp 1111", be); end
        tests++; if (mw !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wst_wdata got %h exp deadbeef", mw); end
        tests++; if (mwe !== 1'b1) begin fails++; $display("FAIL wst_we got %b exp 1", mwe); end
        tests++; if (reqc != 3) begin fails++; $display("FAIL wst_req_cycles got %0d exp 3", reqc); end
        tests++; if (st !== 1'b1) begin fails++; $display("FAIL wst_stable got %b exp 1", st); end
        tests++; if (lat != 3) begin fails++; $display("FAIL wst_latency got %0d exp 3", lat); end
        tests++; if (ex !== 2'b00 || rd !== 32'h0) begin fails++; $display("FAIL wst_rsp got exc %b rdata %h exp 00 0", ex, rd); end
        tests++; if (busy !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL wst_busy_rsp got busy %b req %b exp 1 0", busy, mem_req); end
        step();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL wst_after got v %b rdy %b busy %b exp 0 1 0", rsp_valid, req_ready, busy); end
        tests++; if (rsp_exc !== 2'b00 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL wst_rsp_clear got %b %h exp 00 0", rsp_exc, rsp_rdata); end
    endtask

    task automatic test_byte_store();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (be !== 4'b1000) begin fails++; $display("FAIL bst_be got %b exp 1000", be); end
        tests++; if (mw !== 32'hA5A5_A5A5) begin fails++; $display("FAIL bst_wdata got %h exp a5a5a5a5", mw); end
        tests++; if (ma !== 32'h10) begin fails++; $display("FAIL bst_addr got %h exp 00000010", ma); end
        tests++; if (lat != 1 || reqc != 1) begin fails++; $display("FAIL bst_timing got lat %0d req %0d exp 1 1", lat, reqc); end
        step();
    endtask

    task automatic test_signed_byte_load();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b0, 2'b10, 1'b1, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL sbl_rdata got %h exp ffffff80", rd); end
        tests++; if (lat != 1) begin fails++; $display("FAIL sbl_latency got %0d exp 1", lat); end
        tests++; if (be !== 4'b0010 || mwe !== 1'b0) begin fails++; $display("FAIL sbl_lanes got be %b we %b exp 0010 0", be, mwe); end
        tests++; if (ex !== 2'b00) begin fails++; $display("FAIL sbl_exc got %b exp 00", ex); end
        step();
    endtask

    task automatic test_half_loads();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 32'h8001_0000, 1,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'h0000_8001) begin fails++; $display("FAIL hlu_rdata got %h exp 00008001", rd); end
        tests++; if (be !== 4'b1100 || ma !== 32'h20) begin fails++; $display("FAIL hlu_lanes got be %b addr %h exp 1100 00000020", be, ma); end
        step();
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 32'h8001_0000, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'hFFFF_8001) begin fails++; $display("FAIL hls_rdata got %h exp ffff8001", rd); end
        step();
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0, 32'h8001_7ABC, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'h0000_7ABC || be !== 4'b0011) begin fails++; $display("FAIL hll_rdata got %h be %b exp 00007abc 0011", rd, be); end
        step();
    endtask

    task automatic test_misaligned();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (ex !== 2'b01 || reqc != 0 || lat != 0) begin
            fails++; $display("FAIL mis_word_ld got exc %b req %0d lat %0d exp 01 0 0", ex, reqc, lat); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_word_rdata got %h exp 0", rd); end
        step();
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h1234_5678, 32'h0, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (ex !== 2'b10 || reqc != 0 || lat != 0) begin
            fails++; $display("FAIL mis_half_st got exc %b req %0d lat %0d exp 10 0 0", ex, reqc, lat); end
        step();
        run_req(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 32'h2222_2222, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (ex !== 2'b01 || reqc != 0 || lat != 0) begin
            fails++; $display("FAIL mis_reserved got exc %b req %0d lat %0d exp 01 0 0", ex, reqc, lat); end
        step();
        tests++; if (req_ready !== 1'b1 || rsp_exc !== 2'b00) begin fails++; $display("FAIL mis_after got rdy %b exc %b exp 1 00", req_ready, rsp_exc); end
    endtask

    task automatic test_back_to_back();
        int lat, reqc; logic [3:0] be; logic [31:0] ma, mw, rd; logic mwe, st; logic [1:0] ex;
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0043, 32'h0, 32'h9A00_0000, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'h0000_009A) begin fails++; $display("FAIL b2b_ld1 got %h exp 0000009a", rd); end
        step();
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0,
                lat, reqc, be, ma, mw, mwe, rd, ex, st);
        tests++; if (rd !== 32'hCAFE_F00D || ma !== 32'h44 || lat != 1) begin
            fails++; $display("FAIL b2b_ld2 got %h addr %h lat %0d exp cafef00d 00000044 1", rd, ma, lat); end
        step();
    endtask

    task automatic test_reset_mid_access();
        int seen;
        req_valid = 1'b1; req_we = 1'b0; req_align = 2'b00; req_addr = 32'h0000_0080;
        step();
        req_valid = 1'b0;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rma_req_before got %b exp 1", mem_req); end
        #2 rst = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rma_req_drop got req %b busy %b exp 0 0", mem_req, busy); end
        step();
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        seen = 0;
        repeat (4) begin
            step();
            if (rsp_valid === 1'b1 || mem_req === 1'b1) seen++;
        end
        mem_ack = 1'b0;
        tests++; if (seen != 0) begin fails++; $display("FAIL rma_no_rsp got %0d active cycles exp 0", seen); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rma_ready got %b exp 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_signed_byte_load();
        test_half_loads();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit on the CPU side of the data-memory interface. Accepts one load or store per transaction from the memory pipeline stage and checks alignment. Drives a word-addressed, byte-enabled memory request with a req/ack handshake, then returns the extracted and sign- or zero-extended load data. Sits between the MEM stage and data memory, and holds `busy` high so the pipeline stalls while an access is outstanding.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset; 0 = reset.
- `req_valid` input 1: pipeline presents an access this cycle.
- `req_ready` output 1: high only in IDLE; a request is accepted on the edge where `req_valid & req_ready`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_align` input 2: 00 = word, 01 = halfword, 10 = byte, 11 = reserved.
- `req_sign` input 1: load extension; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `busy` output 1: high from acceptance until the rsp cycle ends, inclusive.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_rdata` output 32: load result, valid with `rsp_valid`; 0 for stores and exceptions.
- `rsp_exc` output 2: 00 = none, 01 = load address error (AdEL), 10 = store address error (AdES); valid with `rsp_valid`.
- `mem_req` output 1: memory request; held until `mem_ack`.
- `mem_we` output 1: write strobe qualifier.
- `mem_addr` output 32: `{addr[31:2],2'b00}`.
- `mem_be` output 4: byte lanes accessed.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: memory completes the access; may be high in the first `mem_req` cycle.
- `mem_rdata` input 32: read word, valid when `mem_ack` is high.

## Operation
- **States.** IDLE, ACCESS, RESP.
- **IDLE.** `req_ready`=1.
  - On accept, latch we, align, sign, addr and wdata.
  - A request is misaligned if align=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Misaligned → go to RESP with `rsp_exc` = AdEL (load) or AdES (store). `mem_req` never rises.
  - Aligned → go to ACCESS.
- **ACCESS.** `mem_req`=1, and all `mem_*` outputs stay constant.
  - On `mem_ack`=1, compute the load result from `mem_rdata` and register it, then go to RESP.
  - Stores register `rsp_rdata`=0.
- **RESP.** `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- **Byte enables.**
  - word: 1111.
  - half: 0011 if `addr[1]`=0, 1100 if `addr[1]`=1.
  - byte: 0001 shifted left by `addr[1:0]`.
  - The same lanes are driven for loads.
- **Write data.**
  - word: wdata.
  - half: `{2{wdata[15:0]}}`.
  - byte: `{4{wdata[7:0]}}`.
- **Load extraction.** Select the lane(s) named by `addr[1:0]`. Extend from the lane MSB if sign=1, else with zeros.
  - Example: byte at offset 3 takes `rdata[31:24]`.
- **Reset.** All outputs are 0 except `req_ready`=1. The state is IDLE.
- **Reset mid-access.** `mem_req` drops immediately (asynchronously). No `rsp_valid` is produced for the aborted access.
- **Illegal state encoding.** Return to IDLE.

## Timing
- Requests are accepted at edge T0.
- Aligned access:
  - `mem_req` is high from T0 until the edge where `mem_ack` is sampled (Ta).
  - `rsp_valid` is high in the cycle after Ta.
  - `req_ready` returns one cycle after `rsp_valid`.
- Minimum latency (ack in the first ACCESS cycle): accept → `rsp_valid` is 2 cycles, and the next accept is possible 3 cycles after T0.
- Exception: `rsp_valid` is high the cycle after T0, with no memory traffic.
- `mem_ack` is ignored outside ACCESS.
- `req_valid` is ignored outside IDLE; the pipeline must hold the request until it is accepted.
- `busy` = (state ≠ IDLE); it is registered, with no combinational path from `req_valid`.
- `rsp_rdata` and `rsp_exc` hold their values only during `rsp_valid`, and are 0 otherwise.

## Test plan
- **Reset checks.** Hold `rst`=0 for 3 cycles, then release.
  - Required: `req_ready`=1; `mem_req`=0; `rsp_valid`=0; `busy`=0.
  - Separately, assert `rst`=0 during ACCESS: `mem_req` falls the same cycle, with no response.
- **Word store.** Addr 0x0000_0010, wdata 0xDEAD_BEEF, ack after 2 wait cycles.
  - Required: `mem_addr`=0x10; `mem_be`=1111; `mem_wdata`=0xDEAD_BEEF.
  - `mem_req` stays high for 3 cycles, then one `rsp_valid` with `rsp_exc`=00.
- **Byte store.** Addr 0x13, wdata 0x0000_00A5.
  - Required: `mem_be`=1000; `mem_wdata`=0xA5A5_A5A5.
- **Signed byte load.** Addr 0x21, `mem_rdata`=0x1234_80FF, immediate ack.
  - Required: `rsp_rdata`=0xFFFF_FF80, with `rsp_valid` 2 cycles after accept.
- **Halfword loads.** Addr 0x22 with `mem_rdata`=0x8001_0000.
  - Unsigned load → `rsp_rdata`=0x0000_8001.
  - Signed load → `rsp_rdata`=0xFFFF_8001.
- **Misaligned requests.** Word load at 0x0000_0006, halfword store at 0x0000_0003, and a reserved (align=11) load at 0x0000_0010.
  - Required: `mem_req` never rises; `rsp_valid` the cycle after accept.
  - `rsp_exc`=01 for the word load, 10 for the halfword store, and 01 for the reserved load.
